// File: rtl/ts_stub_wr_pkg.sv
// Shared track-stub memory constants and FSM encoding,
// used by both the write and read sides.
package ts_stub_wr_pkg;

  localparam int CROSS_NUM_BUF_ADR_BITS = 4;
  localparam int STUB_ADR_BITS = 10;
  localparam int STUB_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLOSE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ts_stub_wr_adr_cntr.sv
// Region address counter {cn, index} plus saturating stub count.
// TS_STUB_WR_SAT_EN: stop at a full region and flag the drop.
module ts_stub_wr_adr_cntr
  import ts_stub_wr_pkg::*;
#(
  parameter int CN_BITS = CROSS_NUM_BUF_ADR_BITS,
  parameter int LOW = STUB_ADR_BITS - CROSS_NUM_BUF_ADR_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [CN_BITS-1:0] cn_i,
  input  logic               inc_i,
  output logic [CN_BITS+LOW-1:0] adr_o,
  output logic [LOW:0]       cnt_o,
  output logic               wr_o,
  output logic               ovf_o
);

  localparam logic [LOW:0] FULL = {1'b1, {LOW{1'b0}}};

  logic [CN_BITS-1:0] cn_q, cn_d;
  logic [LOW-1:0]     idx_q, idx_d;
  logic [LOW:0]       cnt_q, cnt_d;
  logic               full;

  assign full  = (cnt_q == FULL);
  assign adr_o = {cn_q, idx_q};
  assign cnt_o = cnt_q;

`ifdef TS_STUB_WR_SAT_EN
  logic ovf_q;

  assign wr_o  = inc_i & ~full;
  assign ovf_o = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (load_i) begin
      ovf_q <= 1'b0;
    end else if (inc_i && full) begin
      ovf_q <= 1'b1;
    end
  end
`else
  // Index wraps, so excess stubs overwrite from the region base.
  assign wr_o  = inc_i;
  assign ovf_o = 1'b0;
`endif

  always_comb begin
    cn_d  = cn_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load_i) begin
      cn_d  = cn_i;
      idx_d = '0;
      cnt_d = '0;
    end else if (inc_i) begin
      if (wr_o) idx_d = idx_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cn_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      cn_q  <= cn_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ts_stub_wr_ctrl.sv
// Track-stub memory write controller: framing FSM, registered
// write port, close report and sticky protocol error.
module ts_stub_wr_ctrl
  import ts_stub_wr_pkg::*;
#(
  parameter int CN_BITS   = ts_stub_wr_pkg::CROSS_NUM_BUF_ADR_BITS,
  parameter int ADR_BITS  = ts_stub_wr_pkg::STUB_ADR_BITS,
  parameter int STUB_BITS = ts_stub_wr_pkg::STUB_BITS,
  localparam int LOW = ADR_BITS - CN_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bx_start,
  input  logic [CN_BITS-1:0]   cross_num,
  input  logic                 stub_vld,
  input  logic [STUB_BITS-1:0] stub_data,
  input  logic                 bx_end,
  output logic                 mem_we,
  output logic [ADR_BITS-1:0]  mem_adr,
  output logic [STUB_BITS-1:0] mem_din,
  output logic                 busy,
  output logic                 done,
  output logic [CN_BITS-1:0]   done_cross_num,
  output logic [LOW:0]         done_cnt,
  output logic                 ovf,
  output logic                 err
);

  wr_state_e state_q, state_d;
  logic load, inc, err_set;
  logic [ADR_BITS-1:0] c_adr;
  logic [LOW:0] c_cnt;
  logic c_wr, c_ovf;

  ts_stub_wr_adr_cntr #(
    .CN_BITS(CN_BITS),
    .LOW(LOW)
  ) u_cntr (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .cn_i(cross_num),
    .inc_i(inc),
    .adr_o(c_adr),
    .cnt_o(c_cnt),
    .wr_o(c_wr),
    .ovf_o(c_ovf)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        err_set = stub_vld;
        if (bx_start) begin
          load    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        inc     = stub_vld;
        err_set = bx_start;
        if (bx_end) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        err_set = stub_vld | bx_start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mem_we         <= 1'b0;
      mem_adr        <= '0;
      mem_din        <= '0;
      done           <= 1'b0;
      done_cross_num <= '0;
      done_cnt       <= '0;
      ovf            <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_we  <= c_wr;
      mem_adr <= c_adr;
      mem_din <= stub_data;
      done    <= (state_q == ST_CLOSE);
      err     <= err | err_set;
      // Report fields hold between closes.
      if (state_q == ST_CLOSE) begin
        done_cross_num <= c_adr[ADR_BITS-1 -: CN_BITS];
        done_cnt       <= c_cnt;
        ovf            <= c_ovf;
      end
    end
  end

endmodule

// File: doc/ts_stub_wr_ctrl.md
# ts_stub_wr_ctrl

Write-side controller for the track-stub memory. It accepts a framed stream of stubs for one bunch crossing at a time and writes each stub to the memory region selected by the crossing number: upper address bits = buffer crossing number, lower bits = stub index from 0. When a crossing closes, it reports the stub count so the read side knows how many addresses to fetch from the region base.

## Interface
- CN_BITS, 4: crossing-number buffer address bits (= `CROSS_NUM_BUF_ADR_BITS`).
- ADR_BITS, 10: stub memory address bits (= `STUB_ADR_BITS`); LOW = ADR_BITS-CN_BITS, default 6 (64 stubs/region).
- STUB_BITS, 32: stub word width.

Ports:
- clk  in  1  fast processing clock
- rst  in  1  reset, asynchronous, active-high
- bx_start  in  1  open a new crossing; cross_num sampled same cycle
- cross_num  in  CN_BITS  buffer crossing number for the region
- stub_vld  in  1  stub_data valid
- stub_data  in  STUB_BITS  stub word
- bx_end  in  1  close the crossing; may coincide with the final stub_vld
- mem_we  out  1  memory write enable
- mem_adr  out  ADR_BITS  write address
- mem_din  out  STUB_BITS  write data
- busy  out  1  crossing open or closing; upstream holds bx_start while high
- done  out  1  one-cycle pulse, crossing closed
- done_cross_num  out  CN_BITS  crossing number of the closed crossing
- done_cnt  out  LOW+1  stubs stored, 0..2^LOW
- ovf  out  1  stubs dropped in the closed crossing; valid with done
- err  out  1  sticky protocol error

## Operation
- States: IDLE, WRITE, CLOSE. All outputs reset to 0; state resets to IDLE.
- IDLE: bx_start=1 -> latch cross_num, clear index, count and ovf, go to WRITE. A bx_end in the same cycle is ignored.
- WRITE: stub_vld=1 with count<2^LOW -> write {cn, index}, then index++ and count++. With count=2^LOW, drop the stub and set ovf.
- WRITE: bx_end=1 -> go to CLOSE. A coincident stub_vld is processed first.
- CLOSE: one cycle, then IDLE.
- stub_vld in IDLE or CLOSE: stub dropped, err set. bx_start in WRITE or CLOSE: ignored, err set. bx_end in IDLE or CLOSE: ignored, no error.
- err is cleared only by rst.
- busy = (state != IDLE).
- Count arithmetic is LOW+1 bits and saturates at 2^LOW. The index is LOW bits.
- Reset mid-crossing: immediate return to IDLE. No done and no mem_we are issued for the aborted crossing.

## Timing
- Write path is registered. stub_vld sampled at edge k -> mem_we/mem_adr/mem_din valid in cycle k+1.
- bx_end sampled at edge k:
  - CLOSE occupies cycle k+1, which carries the last mem_we.
  - done, done_cross_num, done_cnt and ovf are registered and valid in cycle k+2.
  - busy is low in cycle k+2, so the next bx_start is accepted at the edge ending cycle k+2.
- done_cross_num, done_cnt and ovf hold their values until the next done.
- Minimum crossing period: 3 cycles (bx_start, bx_end, close).

## Configuration
- `TS_STUB_WR_SAT_EN` defined: at 2^LOW stubs the index stops, excess stubs are dropped, and ovf reports the drop.
- `TS_STUB_WR_SAT_EN` undefined: the index wraps modulo 2^LOW, so excess stubs overwrite the region from base. done_cnt still saturates at 2^LOW, and ovf is tied to 0.

## Structure
- Shared constants file: `CROSS_NUM_BUF_ADR_BITS`, `STUB_ADR_BITS`, `STUB_BITS`, and the state encoding (IDLE/WRITE/CLOSE), used by both the write and read sides.
- One sub-module, ts_stub_wr_adr_cntr. It holds the load / increment / hold counter that forms {cn, index} and the saturating count, and contains the `TS_STUB_WR_SAT_EN` logic.
- ts_stub_wr_ctrl holds the FSM, the output registers and error detection.

## Test plan
- bx_start with cross_num=3, then 3 stubs, bx_end with the third -> writes at 0xC0, 0xC1, 0xC2. done 2 cycles after bx_end with done_cross_num=3, done_cnt=3, ovf=0.
- bx_start with cross_num=5, then bx_end next cycle with no stubs -> no mem_we; done with done_cnt=0 and region 0x140 untouched.
- 70 stubs into cross_num=1:
  - With `TS_STUB_WR_SAT_EN`: last write at 0x7F, done_cnt=64, ovf=1.
  - Without it: stubs 65..70 written at 0x40..0x45, done_cnt=64, ovf=0.
- bx_start during WRITE, and stub_vld in IDLE -> both ignored, no extra mem_we, err=1 until rst.
- rst asserted after 2 stubs of cross_num=7 -> all outputs 0 immediately, no done. The next crossing with cross_num=7 restarts at 0x1C0.
- Back-to-back crossings (cross_num=2 then 9), second bx_start in the cycle done pulses -> both accepted, each done reports its own crossing number and count.
